// File: rtl/key_conditioner.sv
// key_conditioner -- pushbutton front end for the timer.
//
// Each raw, bouncing, active-low KEY pin becomes a clean set of CLOCK_50
// signals: a debounced level, one-cycle press/release pulses and a press
// pulse that auto-repeats while the key is held.
//
// `release` and `repeat` are reserved words in SystemVerilog, so those two
// outputs are named release_pulse and repeat_pulse.
//
// Ports (key_conditioner):
//   CLOCK_50       in   1      system clock, rising edge
//   reset          in   1      synchronous, active-high
//   KEY            in   NKEYS  raw pushbuttons, 0 = pressed
//   level          out  NKEYS  debounced state, 1 = pressed
//   press          out  NKEYS  one-cycle pulse on debounced press
//   release_pulse  out  NKEYS  one-cycle pulse on debounced release
//   repeat_pulse   out  NKEYS  pulse on press, then auto-repeat while held

// One key channel: synchroniser, debouncer, edge pulses, auto-repeat.
module key_chan #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic key,
   output logic level,
   output logic press,
   output logic release_pulse,
   output logic repeat_pulse
);
   localparam int DW   = $clog2(DEBOUNCE_CYCLES);
   localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

   localparam logic [DW-1:0] D_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] RD_LAST  = HW'(REPEAT_DELAY - 1);
   localparam logic [HW-1:0] RP_LAST  = HW'(REPEAT_PERIOD - 1);

   logic          sync1, sync2;
   logic          p;
   logic          lvl_nxt;
   logic [DW-1:0] dcnt, dcnt_nxt;
   logic [HW-1:0] hcnt;
   logic          rep_phase;
   logic          rep_hit;

   always_comb begin
      p        = ~sync2;
      lvl_nxt  = level;
      dcnt_nxt = '0;
      // Count only while the synchronised value disagrees with the level;
      // any agreement (a bounce back) restarts the count from zero.
      if (p != level) begin
         if (dcnt == D_LAST) lvl_nxt  = p;
         else                dcnt_nxt = dcnt + 1'b1;
      end
      // Terminal count of the current hold phase. The press cycle itself is
      // excluded: hcnt is being restarted there.
      rep_hit = level & ~press & (rep_phase ? (hcnt == RP_LAST) : (hcnt == RD_LAST));
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         sync1         <= 1'b1;
         sync2         <= 1'b1;
         dcnt          <= '0;
         level         <= 1'b0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
         repeat_pulse  <= 1'b0;
         hcnt          <= '0;
         rep_phase     <= 1'b0;
      end else begin
         sync1         <= key;
         sync2         <= sync1;
         dcnt          <= dcnt_nxt;
         level         <= lvl_nxt;
         // Pulses are computed from the next level so they appear in the
         // same cycle the level first shows its new value.
         press         <= lvl_nxt & ~level;
         release_pulse <= ~lvl_nxt & level;
         // A release landing on a repeat slot suppresses that repeat.
         repeat_pulse  <= (lvl_nxt & ~level) | (rep_hit & lvl_nxt);

         if (!level) begin
            hcnt      <= '0;
            rep_phase <= 1'b0;
         end else if (press) begin
            // press cycle counts as hold cycle 0
            hcnt      <= HW'(1);
            rep_phase <= 1'b0;
         end else if (rep_hit) begin
            hcnt      <= '0;
            rep_phase <= 1'b1;
         end else begin
            hcnt      <= hcnt + 1'b1;
         end
      end
   end
endmodule

module key_conditioner #(
   parameter int NKEYS           = 4,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic [NKEYS-1:0] KEY,
   output logic [NKEYS-1:0] level,
   output logic [NKEYS-1:0] press,
   output logic [NKEYS-1:0] release_pulse,
   output logic [NKEYS-1:0] repeat_pulse
);
   for (genvar i = 0; i < NKEYS; i++) begin : g_chan
      key_chan #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_chan (
         .CLOCK_50      (CLOCK_50),
         .reset         (reset),
         .key           (KEY[i]),
         .level         (level[i]),
         .press         (press[i]),
         .release_pulse (release_pulse[i]),
         .repeat_pulse  (repeat_pulse[i])
      );
   end
endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3). Cycle t counts edges since the stimulus of a test was
// applied; per channel p_cyc is the cycle its press shows and f_cyc the
// cycle its release shows (1000 = never).
module tb_key_conditioner;
   localparam int NK = 4;
   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RP = 3;
   localparam int NEVER = 1000;

   logic          CLOCK_50 = 1'b0;
   logic          reset;
   logic [NK-1:0] KEY;
   logic [NK-1:0] level, press, release_pulse, repeat_pulse;

   int n_tests = 0;
   int n_fail  = 0;
   int p_cyc[NK];
   int f_cyc[NK];

   always #5 CLOCK_50 = ~CLOCK_50;

   key_conditioner #(
      .NKEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .CLOCK_50      (CLOCK_50),
      .reset         (reset),
      .KEY           (KEY),
      .level         (level),
      .press         (press),
      .release_pulse (release_pulse),
      .repeat_pulse  (repeat_pulse)
   );

   task automatic chk(input string tag, input logic [NK-1:0] got, input logic [NK-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic set_idle();
      for (int i = 0; i < NK; i++) begin
         p_cyc[i] = NEVER;
         f_cyc[i] = NEVER;
      end
   endtask

   // Pulses at the press cycle, press+RD, then every RP while still held.
   function automatic logic is_rep(input int t, input int p, input int f);
      return (t == p) || (t >= p + RD && t < f && ((t - p - RD) % RP) == 0);
   endfunction

   task automatic chk_cycle(input int t, input string name);
      logic [NK-1:0] el, ep, er, et;
      for (int i = 0; i < NK; i++) begin
         el[i] = (t >= p_cyc[i]) && (t < f_cyc[i]);
         ep[i] = (t == p_cyc[i]);
         er[i] = (t == f_cyc[i]);
         et[i] = is_rep(t, p_cyc[i], f_cyc[i]);
      end
      chk($sformatf("%s level t=%0d", name, t), level, el);
      chk($sformatf("%s press t=%0d", name, t), press, ep);
      chk($sformatf("%s release t=%0d", name, t), release_pulse, er);
      chk($sformatf("%s repeat t=%0d", name, t), repeat_pulse, et);
   endtask

   initial begin
      // reset with all keys released
      KEY   = '1;
      reset = 1'b1;
      set_idle();
      for (int t = 1; t <= 20; t++) begin tick(); chk_cycle(t, "reset"); end
      reset = 1'b0;
      for (int t = 1; t <= 5; t++) begin tick(); chk_cycle(t, "idle"); end

      // KEY[1] held: press at 6, repeats 6,16,19,...; released so the level
      // falls at 43, exactly on a repeat slot that must be suppressed
      set_idle();
      KEY[1] = 1'b0;
      p_cyc[1] = 6;  f_cyc[1] = 43;
      for (int t = 1; t <= 50; t++) begin
         tick(); chk_cycle(t, "hold");
         if (t == 37) KEY[1] = 1'b1;
      end

      // KEY[2] bounces 0,1,0,1 then holds 0 from edge 5: level rises at 10
      set_idle();
      KEY[2] = 1'b0;
      p_cyc[2] = 10; f_cyc[2] = 26;
      for (int t = 1; t <= 30; t++) begin
         tick(); chk_cycle(t, "bounce");
         case (t)
            1, 3:    KEY[2] = 1'b1;
            2, 4:    KEY[2] = 1'b0;
            20:      KEY[2] = 1'b1;
            default: ;
         endcase
      end

      // KEY[0] and KEY[3] together; KEY[0] released early, channel 3 keeps
      // repeating undisturbed
      set_idle();
      KEY[0] = 1'b0;
      KEY[3] = 1'b0;
      p_cyc[0] = 6;  f_cyc[0] = 26;
      p_cyc[3] = 6;  f_cyc[3] = 46;
      for (int t = 1; t <= 50; t++) begin
         tick(); chk_cycle(t, "dual");
         if (t == 20) KEY[0] = 1'b1;
         if (t == 40) KEY[3] = 1'b1;
      end

      // KEY[1] held, reset sampled at edge 11: outputs clear with no release,
      // then the held key is re-detected as a new press at 17
      set_idle();
      KEY[1] = 1'b0;
      p_cyc[1] = 6;
      for (int t = 1; t <= 30; t++) begin
         tick();
         if (t == 11) p_cyc[1] = 17;
         chk_cycle(t, "midreset");
         if (t == 10) reset = 1'b1;
         if (t == 11) reset = 1'b0;
      end

      KEY = '1;
      for (int t = 1; t <= 10; t++) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Front-end stage for the pushbutton timer. Turns raw, bouncing, active-low KEY pins into clean per-key signals in the CLOCK_50 domain.
- Per key: synchronises, debounces, produces a level, one-cycle press/release pulses, and a press pulse with hold-to-auto-repeat.
- The timer FSM consumes these outputs for reset, set-timer (hold to step fast) and start/stop instead of edge-triggering on raw KEY.

Parameters:
- NKEYS, 4, number of independent key channels.
- DEBOUNCE_CYCLES, 1000000, cycles the synchronised input must hold stable before the level changes (20 ms at 50 MHz); must be ≥2.
- REPEAT_DELAY, 25000000, cycles from press to first auto-repeat pulse (0.5 s).
- REPEAT_PERIOD, 5000000, cycles between later auto-repeat pulses (0.1 s); must be ≥1.

Ports:
- CLOCK_50  input  1  system clock, all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- KEY  input  NKEYS  raw asynchronous pushbuttons, active-low (0 = pressed).
- level  output  NKEYS  debounced state, active-high (1 = pressed).
- press  output  NKEYS  one-cycle pulse on debounced press.
- release  output  NKEYS  one-cycle pulse on debounced release.
- repeat  output  NKEYS  one-cycle pulse on press, then auto-repeat while held.

Behaviour:
- Channels are fully independent and identical. Simultaneous activity on several keys is handled in parallel with no priority.
- Synchroniser:
  - Two flops per key: sync1 <= KEY, sync2 <= sync1.
  - Working value p = ~sync2.
  - On reset both flops load 1 (released).
- Debounce (counter dcnt, width $clog2(DEBOUNCE_CYCLES)):
  - If p == level, dcnt <= 0.
  - Else if dcnt == DEBOUNCE_CYCLES-1, level <= p and dcnt <= 0.
  - Else dcnt <= dcnt+1.
  - Any glitch back to the current level before the count completes restarts the count from 0.
- Latency: a clean KEY edge before CLOCK_50 edge k changes level at edge k+1+DEBOUNCE_CYCLES, i.e. 2 synchroniser cycles plus DEBOUNCE_CYCLES-1 counting cycles.
- press / release:
  - Registered. Driven from level and its previous value level_q.
  - press = level & ~level_q; release = ~level & level_q.
  - Each is high exactly one cycle, in the first cycle level shows the new value.
- Auto-repeat (hold counter hcnt, width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)), per-key flag rep_phase):
  - repeat is high in the same cycle as press.
  - On the press cycle: hcnt <= 1, rep_phase <= 0.
  - While level==1 and rep_phase==0: when hcnt == REPEAT_DELAY-1, pulse repeat next cycle, hcnt <= 0, rep_phase <= 1; otherwise hcnt increments.
  - While level==1 and rep_phase==1: when hcnt == REPEAT_PERIOD-1, pulse repeat next cycle and hcnt <= 0; otherwise hcnt increments.
  - Resulting pulse times: press cycle P, then P+REPEAT_DELAY, then every REPEAT_PERIOD cycles after that.
  - level==0: hcnt <= 0, rep_phase <= 0, repeat stays 0.
  - Release on the same cycle a repeat would fire suppresses that repeat.
  - Counters never overflow: they are reloaded at terminal count.
- Reset:
  - Values: level=0, level_q=0, press=0, release=0, repeat=0, dcnt=0, hcnt=0, rep_phase=0, sync flops=1.
  - Reset mid-press aborts all counting and emits no pulses.
  - A key still held after reset is treated as a new press: press fires DEBOUNCE_CYCLES+2 cycles after reset deasserts.
  - No release pulse is ever emitted because of reset.
- Outputs are pure registers. No combinational path from KEY to any output.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, NKEYS=4):
- Reset with KEY=4'b1111, hold 20 cycles -> level=0, press/release/repeat=0 throughout.
- KEY[1] driven 0 before edge k and held -> level[1]=1 at edge k+5. press[1]=1 and repeat[1]=1 for exactly that cycle. Other bits stay 0.
- KEY[2] bounces 0,1,0,1 for 1 cycle each, then holds 0 -> level[2] rises 5 cycles after the last 1→0 transition. Exactly one press pulse.
- Hold KEY[1] low 30 cycles after press at cycle P -> repeat[1] pulses at P, P+10, P+13, P+16, P+19, …. Release -> release[1] one cycle, repeat stops.
- KEY[0] and KEY[3] pressed in the same cycle -> press[0] and press[3] both high in the same cycle. Release of KEY[0] does not disturb channel 3 repeats.
- Key held, reset pulsed high 1 cycle at P+5 -> all outputs 0 next cycle, no release pulse. press reappears 6 cycles after reset deasserts.
